mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_rr2.sv | 16 +
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the two-port burst memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int DEF_BURST_LEN   = 4;
    localparam int DEF_BURST_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH  = 32;

    // Beat counter must hold BURST_LEN itself and is never narrower than 3 bits.
    function automatic int beat_cnt_width(input int len);
        int w;
        w = $clog2(len + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin selector producing a one-hot grant
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On a collision the port that did not own the bus last time wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter giving D-cache and I-cache ports whole bursts on one memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   m0_read,
    input  logic                   m0_write,
    input  logic [ADDR_WIDTH-1:0]  m0_address,
    input  logic [BURST_WIDTH-1:0] m0_wdata,
    input  logic [3:0]             m0_byte_enable,
    output logic [BURST_WIDTH-1:0] m0_rdata,
    output logic                   m0_resp,

    input  logic                   m1_read,
    input  logic                   m1_write,
    input  logic [ADDR_WIDTH-1:0]  m1_address,
    input  logic [BURST_WIDTH-1:0] m1_wdata,
    input  logic [3:0]             m1_byte_enable,
    output logic [BURST_WIDTH-1:0] m1_rdata,
    output logic                   m1_resp,

    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [BURST_WIDTH-1:0] mem_wdata,
    output logic [3:0]             mem_byte_enable,
    input  logic [BURST_WIDTH-1:0] mem_rdata,
    input  logic                   mem_resp,

    output logic [1:0]             grant,
    output logic                   busy
);

    localparam int CNT_W = beat_cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    logic [1:0]       req;
    logic [1:0]       gnt;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    arb_rr2 u_rr (
        .req  (req),
        .last (last_q),
        .gnt  (gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Only the beat count ends a grant; request levels are irrelevant once granted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt[0]) begin
                    state_d = GRANT0;
                end else if (gnt[1]) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (mem_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RELEASE;
                        last_d  = (state_q == GRANT1);
                    end
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read wins over write when a port raises both in the same cycle.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        m0_rdata        = '0;
        m0_resp         = 1'b0;
        m1_rdata        = '0;
        m1_resp         = 1'b0;
        grant           = 2'b00;
        busy            = 1'b0;
        case (state_q)
            GRANT0: begin
                mem_read        = m0_read;
                mem_write       = m0_write & ~m0_read;
                mem_address     = m0_address;
                mem_wdata       = m0_wdata;
                mem_byte_enable = m0_byte_enable;
                m0_rdata        = mem_rdata;
                m0_resp         = mem_resp;
                grant           = 2'b01;
                busy            = 1'b1;
            end
            GRANT1: begin
                mem_read        = m1_read;
                mem_write       = m1_write & ~m1_read;
                mem_address     = m1_address;
                mem_wdata       = m1_wdata;
                mem_byte_enable = m1_byte_enable;
                m1_rdata        = mem_rdata;
                m1_resp         = mem_resp;
                grant           = 2'b10;
                busy            = 1'b1;
            end
            RELEASE: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_address, m1_address, m0_wdata, m1_wdata;
    logic [3:0]  m0_byte_enable, m1_byte_enable;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_resp, m1_resp;
    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
    logic [1:0]  grant;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    mem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .m0_read         (m0_read),
        .m0_write        (m0_write),
        .m0_address      (m0_address),
        .m0_wdata        (m0_wdata),
        .m0_byte_enable  (m0_byte_enable),
        .m0_rdata        (m0_rdata),
        .m0_resp         (m0_resp),
        .m1_read         (m1_read),
        .m1_write        (m1_write),
        .m1_address      (m1_address),
        .m1_wdata        (m1_wdata),
        .m1_byte_enable  (m1_byte_enable),
        .m1_rdata        (m1_rdata),
        .m1_resp         (m1_resp),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .grant           (grant),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_read = 0; m0_write = 0; m0_address = 0; m0_wdata = 0; m0_byte_enable = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_wdata = 0; m1_byte_enable = 0;
        mem_rdata = 0; mem_resp = 0;
    endtask

    // n response beats for the currently granted port, checking forwarding and isolation
    task automatic beats(input int port, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            mem_resp  = 1'b1;
            mem_rdata = base + 32'(i);
            #1;
            if (port == 0) begin
                chk("beat_grant0", grant, 2'b01);
                chk("beat_m0_resp", m0_resp, 1'b1);
                chk("beat_m0_rdata", m0_rdata, base + 32'(i));
                chk("beat_m1_resp", m1_resp, 1'b0);
                chk("beat_m1_rdata", m1_rdata, 32'h0);
            end else begin
                chk("beat_grant1", grant, 2'b10);
                chk("beat_m1_resp", m1_resp, 1'b1);
                chk("beat_m1_rdata", m1_rdata, base + 32'(i));
                chk("beat_m0_resp", m0_resp, 1'b0);
                chk("beat_m0_rdata", m0_rdata, 32'h0);
            end
            tick();
        end
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic chk_release();
        #1;
        chk("rel_grant", grant, 2'b00);
        chk("rel_busy", busy, 1'b1);
        chk("rel_mem_read", mem_read, 1'b0);
        chk("rel_mem_write", mem_write, 1'b0);
        chk("rel_mem_address", mem_address, 32'h0);
        tick();
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        mem_resp = 1'b1;
        mem_rdata = 32'h5555_5555;
        m0_read = 1'b1;
        tick();
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_m0_resp", m0_resp, 1'b0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        tick();
        clear_inputs();
        rst = 1'b0;

        // single port-0 read burst
        m0_read = 1'b1; m0_address = 32'h100;
        #1;
        chk("t1_idle_grant", grant, 2'b00);
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_busy", busy, 1'b1);
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_address", mem_address, 32'h100);
        beats(0, 4, 32'hA0);
        m0_read = 1'b0;
        chk_release();

        // collisions: fresh reset makes port 0 win, then port 1 wins the next one
        rst = 1'b1; tick(); rst = 1'b0;
        m0_read = 1'b1; m0_address = 32'h300;
        m1_read = 1'b1; m1_address = 32'h400;
        tick();
        chk("t2_first_grant", grant, 2'b01);
        chk("t2_first_addr", mem_address, 32'h300);
        beats(0, 4, 32'hB0);
        m0_address = 32'h310;
        #1;
        chk("t2_rel_grant", grant, 2'b00);
        tick();
        chk("t2_idle_grant", grant, 2'b00);
        chk("t2_idle_busy", busy, 1'b0);
        tick();
        chk("t2_second_grant", grant, 2'b10);
        chk("t2_second_addr", mem_address, 32'h400);
        beats(1, 4, 32'hC0);
        m1_read = 1'b0;
        chk_release();
        tick();
        chk("t2_third_grant", grant, 2'b01);
        chk("t2_third_addr", mem_address, 32'h310);
        beats(0, 4, 32'hD0);
        m0_read = 1'b0;
        chk_release();

        // port-1 write; request dropped mid-grant; port-0 inputs ignored
        m1_write = 1'b1; m1_address = 32'h200; m1_byte_enable = 4'b0011; m1_wdata = 32'hDEAD_BEEF;
        tick();
        m0_read = 1'b1; m0_address = 32'hBAD0; m0_wdata = 32'h1111_1111; m0_byte_enable = 4'hF;
        #1;
        chk("t3_grant", grant, 2'b10);
        chk("t3_mem_write", mem_write, 1'b1);
        chk("t3_mem_read", mem_read, 1'b0);
        chk("t3_mem_address", mem_address, 32'h200);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t3_mem_be", mem_byte_enable, 4'b0011);
        beats(1, 1, 32'hE0);
        m1_write = 1'b0;
        beats(1, 3, 32'hE1);
        chk_release();

        // port 0 read and write together: read wins
        m0_write = 1'b1;
        tick();
        #1;
        chk("t4_grant", grant, 2'b01);
        chk("t4_mem_read", mem_read, 1'b1);
        chk("t4_mem_write", mem_write, 1'b0);
        chk("t4_mem_address", mem_address, 32'hBAD0);
        beats(0, 4, 32'hF0);
        m0_read = 1'b0; m0_write = 1'b0;
        chk_release();

        // asynchronous reset mid-burst, then a clean port-1 transaction
        m0_read = 1'b1; m0_address = 32'h500;
        tick();
        beats(0, 2, 32'h70);
        mem_resp = 1'b1; mem_rdata = 32'h77;
        rst = 1'b1;
        #1;
        chk("t5_rst_grant", grant, 2'b00);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_mem_read", mem_read, 1'b0);
        chk("t5_rst_mem_address", mem_address, 32'h0);
        chk("t5_rst_m0_resp", m0_resp, 1'b0);
        chk("t5_rst_m0_rdata", m0_rdata, 32'h0);
        tick();
        rst = 1'b0; m0_read = 1'b0; mem_resp = 1'b0; mem_rdata = 32'h0;
        m1_read = 1'b1; m1_address = 32'h600;
        #1;
        chk("t5_idle_grant", grant, 2'b00);
        tick();
        chk("t5_grant", grant, 2'b10);
        chk("t5_mem_address", mem_address, 32'h600);
        beats(1, 4, 32'h80);
        m1_read = 1'b0;
        chk_release();

        // spurious responses in IDLE are dropped
        mem_resp = 1'b1; mem_rdata = 32'hAAAA;
        #1;
        chk("t6_m0_resp", m0_resp, 1'b0);
        chk("t6_m1_resp", m1_resp, 1'b0);
        chk("t6_m0_rdata", m0_rdata, 32'h0);
        chk("t6_busy", busy, 1'b0);
        tick();
        tick();
        mem_resp = 1'b0; mem_rdata = 32'h0;
        m0_read = 1'b1; m0_address = 32'h700;
        tick();
        chk("t6_grant", grant, 2'b01);
        beats(0, 3, 32'h90);
        #1;
        chk("t6_still_granted", grant, 2'b01);
        chk("t6_still_busy", busy, 1'b1);
        beats(0, 1, 32'h93);
        m0_read = 1'b0;
        chk_release();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
